// File: rtl/traffic_pkg.sv
// Light codes and pedestrian phase encoding shared between the vehicle
// traffic-light FSM and the pedestrian crossing controller.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2
    } ped_state_e;

    function automatic logic is_legal_light(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: grants WALK on a fresh vehicle Red when a
// request is latched, follows it with a flashing clearance, else DONT_WALK.
module ped_signal_ctrl
    import traffic_pkg::*;
#(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             light_err
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    ped_state_e       state_q;
    logic [2:0]       prev_light_q;
    logic             walk_q;
    logic             dont_walk_q;
    logic [CNT_W-1:0] countdown_q;
    logic             req_pending_q;
    logic             light_err_q;

    logic light_legal_d;
    logic light_red_d;
    logic red_entry_d;
    logic req_eff_d;

    always_comb begin
        light_legal_d = is_legal_light(light);
        light_red_d   = (light == LIGHT_RED);
        red_entry_d   = light_red_d && (prev_light_q != LIGHT_RED);
        req_eff_d     = req_pending_q | ped_btn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            prev_light_q  <= LIGHT_RED;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
            countdown_q   <= '0;
            req_pending_q <= 1'b0;
            light_err_q   <= 1'b0;
        end else begin
            prev_light_q <= light;
            light_err_q  <= ~light_legal_d;

            case (state_q)
                IDLE: begin
                    walk_q      <= 1'b0;
                    dont_walk_q <= 1'b1;
                    countdown_q <= '0;
                    if (red_entry_d && req_eff_d && light_legal_d) begin
                        // The press that opens WALK is consumed, not latched.
                        state_q       <= WALK;
                        walk_q        <= 1'b1;
                        dont_walk_q   <= 1'b0;
                        countdown_q   <= WALK_LOAD;
                        req_pending_q <= 1'b0;
                    end else if (ped_btn) begin
                        req_pending_q <= 1'b1;
                    end
                end

                WALK: begin
                    if (!light_red_d) begin
                        state_q     <= IDLE;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        countdown_q <= '0;
                    end else if (countdown_q == '0) begin
                        state_q     <= FLASH;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        countdown_q <= FLASH_LOAD;
                    end else begin
                        countdown_q <= countdown_q - CNT_ONE;
                    end
                end

                FLASH: begin
                    // Requests made during clearance wait for the next Red.
                    if (ped_btn) begin
                        req_pending_q <= 1'b1;
                    end
                    walk_q <= 1'b0;
                    if (!light_red_d || (countdown_q == '0)) begin
                        state_q     <= IDLE;
                        dont_walk_q <= 1'b1;
                        countdown_q <= '0;
                    end else begin
                        dont_walk_q <= ~dont_walk_q;
                        countdown_q <= countdown_q - CNT_ONE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    walk_q      <= 1'b0;
                    dont_walk_q <= 1'b1;
                    countdown_q <= '0;
                end
            endcase
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign countdown   = countdown_q;
    assign req_pending = req_pending_q;
    assign light_err   = light_err_q;

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
Pedestrian crossing controller directly downstream of the vehicle traffic-light FSM. It consumes the FSM's one-hot light code and a pedestrian push-button. It grants a WALK phase only during a fresh vehicle Red, then a flashing-clearance phase, and forces solid DONT_WALK at all other times. All outputs are registered; this block is the only driver of the crossing lamps and countdown display.

Parameters:
WALK_CYCLES, 8, length of the solid WALK phase in clk cycles; legal range 1..2^CNT_W.
FLASH_CYCLES, 4, length of the flashing-clearance phase in clk cycles; legal range 1..2^CNT_W.
CNT_W, 4, width of the countdown output.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
light  input  3  vehicle light code from the upstream FSM: 100=Red, 010=Yellow, 001=Green.
ped_btn  input  1  pedestrian request button, synchronous level; a single-cycle pulse is sufficient.
walk  output  1  WALK lamp.
dont_walk  output  1  DONT_WALK lamp; toggles during clearance.
countdown  output  CNT_W  remaining cycles in the current WALK or FLASH phase; 0 in IDLE.
req_pending  output  1  a latched request is waiting for the next Red.
light_err  output  1  light input was not a legal one-hot code in the previous cycle.

Behaviour:
- Reset (async assert, values hold while rst=1): state=IDLE, walk=0, dont_walk=1, countdown=0, req_pending=0, light_err=0, prev_light=100.
  - Because prev_light resets to Red, a light that is already Red at reset does not produce a WALK; the first WALK requires a full new Red.
- Internal signals:
  - red_entry = (light==100) && (prev_light!=100).
  - prev_light registers light every cycle.
  - req_eff = req_pending | ped_btn.
- States and transitions, evaluated per clk edge:
  - IDLE: walk=0, dont_walk=1, countdown=0.
    - If red_entry && req_eff && light legal: go to WALK, countdown<=WALK_CYCLES-1, req_pending<=0.
  - WALK: walk=1, dont_walk=0.
    - countdown decrements by 1 each cycle.
    - When countdown==0: go to FLASH, countdown<=FLASH_CYCLES-1, dont_walk<=1.
    - WALK therefore lasts exactly WALK_CYCLES cycles.
  - FLASH: walk=0; dont_walk inverts every cycle, starting at 1 on entry.
    - countdown decrements by 1 each cycle.
    - When countdown==0: go to IDLE, dont_walk<=1.
- Safety abort: in WALK or FLASH, if light!=100 on any edge, go to IDLE the next cycle with walk=0, dont_walk=1, countdown=0. The request is not re-armed.
- Request latch:
  - In IDLE or FLASH, ped_btn=1 sets req_pending the next cycle.
  - In WALK, ped_btn is ignored.
  - A press on the same edge that enters WALK is consumed, so req_pending stays 0.
- Illegal light code (any value other than 100/010/001):
  - light_err<=1 next cycle; it clears on the first cycle after a legal code is seen.
  - Aborts WALK/FLASH to IDLE exactly as above.
  - Blocks WALK entry.
  - req_pending is retained.
- Latency: every output reflects inputs sampled one clk edge earlier. There is no combinational path from input to output.
- Countdown never underflows and never wraps; its arithmetic is unsigned, CNT_W bits.
- Invariant: walk && dont_walk is never 1 at the same time. The bench must assert this every cycle.

Decomposition:
- Shared package (traffic_pkg):
  - Light-code constants LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001, shared with the vehicle FSM.
  - Pedestrian state enum {IDLE, WALK, FLASH}.
- No sub-module. The countdown and request latch stay inline. Target size is roughly 150 lines.

Test Plan:
All scenarios use WALK_CYCLES=4, FLASH_CYCLES=2.
1. Assert rst mid-operation with light=Green -> immediately walk=0, dont_walk=1, countdown=0, req_pending=0, light_err=0; release with light=Red held -> no WALK ever occurs.
2. Light=Green, 1-cycle ped_btn -> req_pending=1 next cycle; light goes to Red -> next cycle walk=1, countdown 3,2,1,0; then FLASH with dont_walk 1,0 and countdown 1,0; then IDLE with dont_walk=1; req_pending=0 throughout WALK.
3. Same start as scenario 2, but light goes Red→Green while countdown=2 in WALK -> next cycle walk=0, dont_walk=1, countdown=0, req_pending=0, and no FLASH phase occurs.
4. Red entry with no request -> no WALK; ped_btn pressed while Red is held -> req_pending=1 but no WALK until after Green→Yellow→Red, then walk=1 the cycle after Red entry.
5. light=3'b011 for one cycle during FLASH -> light_err=1 and IDLE next cycle with dont_walk=1; light=001 -> light_err=0 the following cycle.
6. ped_btn pressed during WALK -> req_pending stays 0; pressed during FLASH -> req_pending=1, and it is served at the next Red entry.
